// File: rtl/fft_stream_r2.sv
// rtl/fft_stream_r2.sv - streaming radix-2 DIT FFT/IFFT, one butterfly per cycle, ping-pong buffers
// Define FFT_SATURATE_EN to saturate butterfly outputs and report overflow; otherwise results wrap.
module fft_stream_r2 #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 5,
  parameter int TW_WIDTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  input  logic                         inverse,
  input  logic        [LOG2_N-1:0]     scale_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic        [LOG2_N-1:0]     out_index,
  output logic                         out_last,
  output logic                         overflow
);

  localparam int N      = 1 << LOG2_N;
  localparam int HALF_N = N / 2;
  localparam int AW     = LOG2_N;
  localparam int PW     = LOG2_N - 1;
  localparam int MW     = DATA_WIDTH + TW_WIDTH;
  localparam int SW     = DATA_WIDTH + 2;
  localparam bit FINAL_IN_B1 = (LOG2_N % 2) == 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_UNLOAD  = 2'd3;

`ifdef FFT_SATURATE_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic clipped(input logic signed [SW-1:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction
`endif

  // Q(TW_WIDTH-2) cos/sin of 2*pi*k/N, rounded to nearest
  function automatic logic signed [TW_WIDTH-1:0] twiddle(input int k, input bit want_sin);
    real ang;
    real v;
    ang = 6.283185307179586 * real'(k) / real'(N);
    v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(longint'(1) << (TW_WIDTH - 2));
    return TW_WIDTH'((v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5));
  endfunction

  function automatic logic signed [SW-1:0] scaled(input logic signed [SW-1:0] v, input logic halve);
    return halve ? (v >>> 1) : v;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [SW-1:0] r);
`ifdef FFT_SATURATE_EN
    if (r > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (r < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
`endif
    return DATA_WIDTH'(r);
  endfunction

  logic [1:0]    state;
  logic [AW-1:0] load_cnt;
  logic [3:0]    stage;
  logic [PW-1:0] pair;
  logic          inv_q;
  logic [AW-1:0] mask_q;

  logic signed [DATA_WIDTH-1:0] b0_re [N];
  logic signed [DATA_WIDTH-1:0] b0_im [N];
  logic signed [DATA_WIDTH-1:0] b1_re [N];
  logic signed [DATA_WIDTH-1:0] b1_im [N];

  logic signed [TW_WIDTH-1:0] rom_cos [HALF_N];
  logic signed [TW_WIDTH-1:0] rom_sin [HALF_N];

  for (genvar g = 0; g < HALF_N; g++) begin : g_rom
    assign rom_cos[g] = twiddle(g, 1'b0);
    assign rom_sin[g] = twiddle(g, 1'b1);
  end

  logic [AW-1:0] span_bit, span_mask, pair_ext, idx_a, idx_b, load_addr, rd_addr;
  logic [PW-1:0] tw_idx;
  logic [3:0]    tw_shift;

  always_comb begin
    span_bit  = AW'(1) << stage;
    span_mask = span_bit - AW'(1);
    pair_ext  = {1'b0, pair};
    idx_a     = ((pair_ext >> stage) << (stage + 4'd1)) | (pair_ext & span_mask);
    idx_b     = idx_a | span_bit;
    tw_shift  = 4'(LOG2_N - 1) - stage;
    tw_idx    = PW'(pair_ext & span_mask) << tw_shift;
    for (int i = 0; i < AW; i++) load_addr[i] = load_cnt[AW-1-i];
    rd_addr   = out_valid ? out_index + AW'(1) : '0;
  end

  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_WIDTH-1:0]   w_cos, w_sin;
  logic signed [MW-1:0]         t_re_w, t_im_w;
  logic signed [SW-1:0]         t_re, t_im, x_re, x_im, y_re, y_im;
  logic signed [DATA_WIDTH-1:0] nx_re, nx_im, ny_re, ny_im;
  logic                         scale_now;

  // Even stages read bank 0 and write bank 1; odd stages the reverse
  always_comb begin
    if (stage[0]) begin
      a_re = b1_re[idx_a];
      a_im = b1_im[idx_a];
      b_re = b1_re[idx_b];
      b_im = b1_im[idx_b];
    end else begin
      a_re = b0_re[idx_a];
      a_im = b0_im[idx_a];
      b_re = b0_re[idx_b];
      b_im = b0_im[idx_b];
    end
    w_cos     = rom_cos[tw_idx];
    w_sin     = inv_q ? -rom_sin[tw_idx] : rom_sin[tw_idx];
    t_re_w    = MW'(b_re) * MW'(w_cos) + MW'(b_im) * MW'(w_sin);
    t_im_w    = MW'(b_im) * MW'(w_cos) - MW'(b_re) * MW'(w_sin);
    t_re      = SW'(t_re_w >>> (TW_WIDTH - 2));
    t_im      = SW'(t_im_w >>> (TW_WIDTH - 2));
    scale_now = |(mask_q & span_bit);
    x_re      = scaled(SW'(a_re) + t_re, scale_now);
    x_im      = scaled(SW'(a_im) + t_im, scale_now);
    y_re      = scaled(SW'(a_re) - t_re, scale_now);
    y_im      = scaled(SW'(a_im) - t_im, scale_now);
    nx_re     = narrow(x_re);
    nx_im     = narrow(x_im);
    ny_re     = narrow(y_re);
    ny_im     = narrow(y_im);
  end

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign out_last = out_valid && (out_index == AW'(N - 1));

  always_ff @(posedge clock) begin
    if (in_valid && in_ready) begin
      b0_re[load_addr] <= in_real;
      b0_im[load_addr] <= in_imag;
    end
    if (state == S_COMPUTE) begin
      if (stage[0]) begin
        b0_re[idx_a] <= nx_re;
        b0_im[idx_a] <= nx_im;
        b0_re[idx_b] <= ny_re;
        b0_im[idx_b] <= ny_im;
      end else begin
        b1_re[idx_a] <= nx_re;
        b1_im[idx_a] <= nx_im;
        b1_re[idx_b] <= ny_re;
        b1_im[idx_b] <= ny_im;
      end
    end
  end

  logic signed [DATA_WIDTH-1:0] fin_re, fin_im;
  assign fin_re = FINAL_IN_B1 ? b1_re[rd_addr] : b0_re[rd_addr];
  assign fin_im = FINAL_IN_B1 ? b1_im[rd_addr] : b0_im[rd_addr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      stage     <= '0;
      pair      <= '0;
      inv_q     <= 1'b0;
      mask_q    <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            inv_q    <= inverse;
            mask_q   <= scale_mask;
            load_cnt <= AW'(1);
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (load_cnt == AW'(N - 1)) begin
              load_cnt <= '0;
              stage    <= '0;
              pair     <= '0;
              state    <= S_COMPUTE;
            end else begin
              load_cnt <= load_cnt + AW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (pair == PW'(HALF_N - 1)) begin
            pair <= '0;
            if (stage == 4'(LOG2_N - 1)) state <= S_UNLOAD;
            else                          stage <= stage + 4'd1;
          end else begin
            pair <= pair + PW'(1);
          end
        end
        S_UNLOAD: begin
          // First UNLOAD cycle primes the output register with bin 0
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_real  <= fin_re;
            out_imag  <= fin_im;
          end else if (out_ready) begin
            if (out_index == AW'(N - 1)) begin
              out_valid <= 1'b0;
              out_index <= '0;
              state     <= S_IDLE;
            end else begin
              out_index <= out_index + AW'(1);
              out_real  <= fin_re;
              out_imag  <= fin_im;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FFT_SATURATE_EN
  logic clip_any;
  assign clip_any = clipped(x_re) | clipped(x_im) | clipped(y_re) | clipped(y_im);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              overflow <= 1'b0;
    else if (state == S_IDLE && in_valid)   overflow <= 1'b0;
    else if (state == S_COMPUTE && clip_any) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stream_r2.sv
// tb/tb_fft_stream_r2.sv - directed bench for fft_stream_r2 (N=32 and N=256 instances)
module tb_fft_stream_r2;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid, in_ready, inverse, out_valid, out_ready, out_last, overflow;
  logic signed [15:0] in_real, in_imag, out_real, out_imag;
  logic        [4:0]  scale_mask, out_index;

  logic               in_valid8, in_ready8, inverse8, out_valid8, out_ready8, out_last8, overflow8;
  logic signed [15:0] in_real8, in_imag8, out_real8, out_imag8;
  logic        [7:0]  scale_mask8, out_index8;

  fft_stream_r2 #(.DATA_WIDTH(16), .LOG2_N(5), .TW_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse), .scale_mask(scale_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last), .overflow(overflow)
  );

  fft_stream_r2 #(.DATA_WIDTH(16), .LOG2_N(8), .TW_WIDTH(16)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_real(in_real8), .in_imag(in_imag8), .inverse(inverse8), .scale_mask(scale_mask8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_real(out_real8), .out_imag(out_imag8),
    .out_index(out_index8), .out_last(out_last8), .overflow(overflow8)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int tx_re [32];
  logic signed [31:0] rx_re [32];
  logic signed [31:0] rx_im [32];
  int cos_tab [8] = '{8192, 5793, 0, -5793, -8192, -5793, 0, 5793};
  int ord_err, stab_err, last_err, last_hits, rx_count, lat, bad, rdy_err, cnt, guard;

`ifdef FFT_SATURATE_EN
  localparam int OVF_BIN0 = 32767;
  localparam int OVF_FLAG = 1;
`else
  localparam int OVF_BIN0 = -32768;
  localparam int OVF_FLAG = 0;
`endif

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic signed [31:0] obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic send32(input bit inv, input logic [4:0] mask, input bit gaps);
    for (int n = 0; n < 32; n++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end
      if (in_ready !== 1'b1) rdy_err++;
      in_valid = 1'b1; in_real = 16'(tx_re[n]); in_imag = 16'sd0;
      inverse = inv; scale_mask = mask;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit junk);
    lat = 0;
    if (junk) begin
      in_valid = 1'b1; in_real = 16'sh7fff; inverse = 1'b1; scale_mask = 5'b0;
    end
    while (lat < 3000) begin
      @(posedge clock); #1;
      lat++;
      if (junk && in_ready !== 1'b0) rdy_err++;
      if (out_valid === 1'b1) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic receive32(input bit bp);
    int idx, ph, g;
    logic p_valid, p_ready;
    logic signed [15:0] p_re, p_im;
    logic [4:0] p_idx;
    idx = 0; ph = 0; g = 0; p_valid = 0; p_ready = 0; p_re = 0; p_im = 0; p_idx = 0;
    ord_err = 0; stab_err = 0; last_err = 0; last_hits = 0;
    while (idx < 32 && g < 2000) begin
      out_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++; g++;
      if (p_valid && !p_ready &&
          (out_valid !== 1'b1 || out_real !== p_re || out_imag !== p_im || out_index !== p_idx))
        stab_err++;
      if (out_valid === 1'b1) begin
        if (out_last !== (out_index == 5'd31)) last_err++;
        if (out_ready) begin
          if (out_index !== 5'(idx)) ord_err++;
          if (out_last === 1'b1) last_hits++;
          rx_re[idx] = out_real;
          rx_im[idx] = out_imag;
          idx++;
        end
      end
      p_valid = out_valid; p_ready = out_ready; p_re = out_real; p_im = out_imag; p_idx = out_index;
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
    rx_count = idx;
  endtask

  task automatic run_frame(input string tag, input bit inv, input logic [4:0] mask,
                           input bit gaps, input bit bp, input bit junk);
    rdy_err = 0;
    send32(inv, mask, gaps);
    wait_valid(junk);
    check({tag, "_latency"}, lat, 81);
    receive32(bp);
    check({tag, "_count"}, rx_count, 32);
    check({tag, "_order"}, ord_err, 0);
    check({tag, "_stable"}, stab_err, 0);
    check({tag, "_last_flag"}, last_err, 0);
    check({tag, "_last_once"}, last_hits, 1);
    check({tag, "_in_ready_busy"}, rdy_err, 0);
    check({tag, "_in_ready_after"}, in_ready, 1);
    check({tag, "_out_valid_after"}, out_valid, 0);
  endtask

  task automatic check_cos(input string tag);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 4 || i == 28) begin
        if (rx_re[i] < 4094 || rx_re[i] > 4098 || iabs(rx_im[i]) > 2) bad++;
      end else if (iabs(rx_re[i]) > 2 || iabs(rx_im[i]) > 2) begin
        bad++;
      end
    end
    check_range({tag, "_bin4"}, rx_re[4], 4094, 4098);
    check_range({tag, "_bin28"}, rx_re[28], 4094, 4098);
    check({tag, "_bins_bad"}, bad, 0);
  endtask

  task automatic check_impulse(input string tag);
    bad = 0;
    for (int i = 0; i < 32; i++) if (rx_re[i] !== 512 || rx_im[i] !== 0) bad++;
    check({tag, "_bin0"}, rx_re[0], 512);
    check({tag, "_bin31"}, rx_re[31], 512);
    check({tag, "_bins_bad"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 0; in_real = 0; in_imag = 0; inverse = 0; scale_mask = 0; out_ready = 0;
    in_valid8 = 0; in_real8 = 0; in_imag8 = 0; inverse8 = 0; scale_mask8 = 8'hff; out_ready8 = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_imag", out_imag, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int n = 0; n < 32; n++) tx_re[n] = (n == 0) ? 16384 : 0;
    run_frame("impulse", 1'b0, 5'b11111, 1'b0, 1'b0, 1'b0);
    check_impulse("impulse");

    for (int n = 0; n < 32; n++) tx_re[n] = 1024;
    run_frame("dc", 1'b0, 5'b11111, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 1; i < 32; i++) if (iabs(rx_re[i]) > 1 || iabs(rx_im[i]) > 1) bad++;
    check("dc_bin0", rx_re[0], 1024);
    check("dc_others_bad", bad, 0);

    for (int n = 0; n < 32; n++) tx_re[n] = cos_tab[n % 8];
    run_frame("cos_fwd", 1'b0, 5'b11111, 1'b0, 1'b0, 1'b0);
    check_cos("cos_fwd");
    run_frame("cos_inv", 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
    check_cos("cos_inv");

    for (int n = 0; n < 32; n++) tx_re[n] = 1024;
    run_frame("ovf", 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    check("ovf_bin0", rx_re[0], OVF_BIN0);
    check("ovf_flag", overflow, OVF_FLAG);

    for (int n = 0; n < 32; n++) tx_re[n] = cos_tab[n % 8];
    run_frame("bp", 1'b0, 5'b11111, 1'b1, 1'b1, 1'b1);
    check_cos("bp");
    check("bp_ovf_cleared", overflow, 0);

    for (int n = 0; n < 32; n++) tx_re[n] = (n == 0) ? 16384 : 0;
    send32(1'b0, 5'b11111, 1'b0);
    repeat (40) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_index", out_index, 0);
    check("midrst_out_real", out_real, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0) cnt++;
    end
    check("midrst_no_output", cnt, 0);
    run_frame("post_rst", 1'b0, 5'b11111, 1'b0, 1'b0, 1'b0);
    check_impulse("post_rst");

    for (int n = 0; n < 256; n++) begin
      in_valid8 = 1'b1;
      in_real8  = (n == 0) ? 16'sd16384 : 16'sd0;
      @(posedge clock); #1;
    end
    in_valid8 = 1'b0;
    lat = 0;
    while (lat < 3000 && out_valid8 !== 1'b1) begin
      @(posedge clock); #1;
      lat++;
    end
    check("n256_latency", lat, 1025);
    out_ready8 = 1'b1;
    bad = 0; cnt = 0; guard = 0;
    while (cnt < 256 && guard < 1000) begin
      guard++;
      if (out_valid8 === 1'b1) begin
        if (out_real8 !== 16'sd64 || out_imag8 !== 16'sd0 || out_index8 !== 8'(cnt)) bad++;
        cnt++;
      end
      @(posedge clock); #1;
    end
    out_ready8 = 1'b0;
    check("n256_count", cnt, 256);
    check("n256_bins_bad", bad, 0);
    check("n256_idle", in_ready8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
